mem_rr_arbiter: RTL and testbench

- Two-requester memory arbiter: the instruction-fetch port (I) and the data load/store port (D) share one single-ported memory that signals completion through a busy line.
- Round-robin grant, one outstanding transaction, address/data/write captured at grant.
- Sits between the core's fetch/LSU ports and the memory model or controller; it is the successor to the fixed-slot TDM arbiter.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_pick2.sv | 34 +++
 rtl/mem_rr_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DDATA_W_DEF = 32;
    localparam int TIMEOUT_DEF = 64;

    // Grant owner encoding, also the encoding of the grantD debug output.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. pick_is_d is combinational; the last-grant
// register only advances when the caller commits the pick with take.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic req_d,
    input  logic take,
    output logic pick_is_d
);

    logic last_d_q;

    // On a tie the port that did not win last time is chosen; otherwise the
    // sole requester wins (with no request the output is don't-care, I).
    always_comb begin
        pick_is_d = req_d;
        if (req_i && req_d) begin
            pick_is_d = ~last_d_q;
        end
    end

    // Remember who was granted so the next tie goes the other way.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_q <= GRANT_I;
        end else if (take) begin
            last_d_q <= pick_is_d;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-ported, busy-handshaked memory
// between the fetch (I) and load/store (D) ports. One transaction in flight.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DDATA_W = DDATA_W_DEF
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  memIAddr,
    input  logic               reqI,
    output logic               memIReady,
    output logic [DDATA_W-1:0] memIRdata,
    input  logic [ADDR_W-1:0]  memDAddr,
    input  logic [DDATA_W-1:0] memDData,
    input  logic               wr,
    input  logic               reqD,
    output logic               memDReady,
    output logic [DDATA_W-1:0] memDRdata,
    output logic [ADDR_W-1:0]  memAddr,
    output logic               memWr,
    output logic [DDATA_W-1:0] memDataIn,
    output logic               memReq,
    input  logic               memBusyIn,
    input  logic [DDATA_W-1:0] memDataOut,
`ifdef ARB_TIMEOUT_EN
    output logic               arbErr,
`endif
    output logic               grantD
);

    arb_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DDATA_W-1:0] wdata_q, wdata_d;
    logic [DDATA_W-1:0] irdata_q, irdata_d;
    logic [DDATA_W-1:0] drdata_q, drdata_d;
    logic               wr_q, wr_d;
    logic               req_q, req_d;
    logic               iready_q, iready_d;
    logic               dready_q, dready_d;
    logic               grant_q, grant_d;
    logic               take;
    logic               pick_is_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    assign arbErr = err_q;
`endif

    // Arbitration only happens in IDLE; requests elsewhere are ignored.
    assign take = (state_q == IDLE) && (reqI || reqD);

    rr_pick2 u_pick (
        .clk       (clk),
        .reset     (reset),
        .req_i     (reqI),
        .req_d     (reqD),
        .take      (take),
        .pick_is_d (pick_is_d)
    );

    // Next-state and registered-output logic for the transaction sequencer.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        wr_d     = wr_q;
        req_d    = req_q;
        grant_d  = grant_q;
        iready_d = 1'b0;
        dready_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (take) begin
                    grant_d = pick_is_d;
                    addr_d  = pick_is_d ? memDAddr : memIAddr;
                    wr_d    = wr & pick_is_d;
                    if (pick_is_d) begin
                        wdata_d = memDData;
                    end
                    req_d   = 1'b1;
                    state_d = ISSUE;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ISSUE: begin
                if (memBusyIn) begin
                    req_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Read data is only valid in the cycle busy is seen low.
                if (!memBusyIn) begin
                    if (grant_q == GRANT_D) begin
                        drdata_d = memDataOut;
                        dready_d = 1'b1;
                    end else begin
                        irdata_d = memDataOut;
                        iready_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                wr_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef ARB_TIMEOUT_EN
        // Watchdog overrides the normal ISSUE/WAIT progress: finish the
        // transaction with zero data and flag the error permanently.
        if (state_q == ISSUE || state_q == WAIT) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                req_d   = 1'b0;
                state_d = DONE;
                err_d   = 1'b1;
                if (grant_q == GRANT_D) begin
                    drdata_d = '0;
                    dready_d = 1'b1;
                    iready_d = 1'b0;
                end else begin
                    irdata_d = '0;
                    iready_d = 1'b1;
                    dready_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            wr_q     <= 1'b0;
            req_q    <= 1'b0;
            iready_q <= 1'b0;
            dready_q <= 1'b0;
            grant_q  <= GRANT_I;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            wr_q     <= wr_d;
            req_q    <= req_d;
            iready_q <= iready_d;
            dready_q <= dready_d;
            grant_q  <= grant_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign memAddr   = addr_q;
    assign memWr     = wr_q;
    assign memDataIn = wdata_q;
    assign memReq    = req_q;
    assign memIReady = iready_q;
    assign memDReady = dready_q;
    assign memIRdata = irdata_q;
    assign memDRdata = drdata_q;
    assign grantD    = grant_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed self-checking bench for mem_rr_arbiter. Defining ARB_TIMEOUT_EN
// also exercises the watchdog with TIMEOUT_CYCLES=8.
module tb_mem_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] memIAddr;
    logic          reqI;
    logic          memIReady;
    logic [DW-1:0] memIRdata;
    logic [AW-1:0] memDAddr;
    logic [DW-1:0] memDData;
    logic          wr;
    logic          reqD;
    logic          memDReady;
    logic [DW-1:0] memDRdata;
    logic [AW-1:0] memAddr;
    logic          memWr;
    logic [DW-1:0] memDataIn;
    logic          memReq;
    logic          memBusyIn;
    logic [DW-1:0] memDataOut;
    logic          grantD;
`ifdef ARB_TIMEOUT_EN
    logic          arbErr;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [DW-1:0] exp_irdata;
    logic [DW-1:0] exp_drdata;

    always #5 clk = ~clk;

    mem_rr_arbiter #(
        .ADDR_W  (AW),
        .DDATA_W (DW)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memIAddr   (memIAddr),
        .reqI       (reqI),
        .memIReady  (memIReady),
        .memIRdata  (memIRdata),
        .memDAddr   (memDAddr),
        .memDData   (memDData),
        .wr         (wr),
        .reqD       (reqD),
        .memDReady  (memDReady),
        .memDRdata  (memDRdata),
        .memAddr    (memAddr),
        .memWr      (memWr),
        .memDataIn  (memDataIn),
        .memReq     (memReq),
        .memBusyIn  (memBusyIn),
        .memDataOut (memDataOut),
`ifdef ARB_TIMEOUT_EN
        .arbErr     (arbErr),
`endif
        .grantD     (grantD)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One memory transaction: wait for memReq, hold busy for lat cycles,
    // return rdata, then check the Ready pulse and the idle cycle after it.
    task automatic xact(input string tag, input int lat, input logic [31:0] rdata,
                        input logic exp_gd, input logic [31:0] exp_addr,
                        input logic exp_wr, input logic [31:0] exp_din,
                        input bit keep, input bit perturb);
        int n;
        n = 0;
        while (!memReq && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ":memReq"}, {31'd0, memReq}, 32'd1);
        chk({tag, ":grantD"}, {31'd0, grantD}, {31'd0, exp_gd});
        chk({tag, ":memAddr"}, memAddr, exp_addr);
        chk({tag, ":memWr"}, {31'd0, memWr}, {31'd0, exp_wr});
        chk({tag, ":memDataIn"}, memDataIn, exp_din);
        memBusyIn = 1'b1;
        for (int k = 0; k < lat; k++) begin
            tick();
            if (k == 0) chk({tag, ":memReq_drop"}, {31'd0, memReq}, 32'd0);
            if (perturb && k == 2) begin
                memDAddr = 32'hFFFF_FFF0;
                memDData = 32'h0000_1234;
                memIAddr = 32'hEEEE_0000;
                wr       = ~wr;
                reqI     = 1'b1;
            end
        end
        chk({tag, ":ready_early"}, {30'd0, memIReady, memDReady}, 32'd0);
        chk({tag, ":addr_hold"}, memAddr, exp_addr);
        chk({tag, ":din_hold"}, memDataIn, exp_din);
        chk({tag, ":wr_hold"}, {31'd0, memWr}, {31'd0, exp_wr});
        memBusyIn  = 1'b0;
        memDataOut = rdata;
        tick();
        if (exp_gd) exp_drdata = rdata;
        else        exp_irdata = rdata;
        chk({tag, ":iready"}, {31'd0, memIReady}, {31'd0, ~exp_gd});
        chk({tag, ":dready"}, {31'd0, memDReady}, {31'd0, exp_gd});
        chk({tag, ":irdata"}, memIRdata, exp_irdata);
        chk({tag, ":drdata"}, memDRdata, exp_drdata);
        if (!keep) begin
            reqI = 1'b0;
            reqD = 1'b0;
        end
        memDataOut = 32'h0BAD_0BAD;
        tick();
        chk({tag, ":ready_clear"}, {30'd0, memIReady, memDReady}, 32'd0);
        chk({tag, ":memWr_clear"}, {31'd0, memWr}, 32'd0);
        chk({tag, ":memReq_idle"}, {31'd0, memReq}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ":memReq"}, {31'd0, memReq}, 32'd0);
        chk({tag, ":memWr"}, {31'd0, memWr}, 32'd0);
        chk({tag, ":ready"}, {30'd0, memIReady, memDReady}, 32'd0);
        chk({tag, ":grantD"}, {31'd0, grantD}, 32'd0);
        chk({tag, ":memAddr"}, memAddr, 32'd0);
        chk({tag, ":memDataIn"}, memDataIn, 32'd0);
        chk({tag, ":irdata"}, memIRdata, 32'd0);
        chk({tag, ":drdata"}, memDRdata, 32'd0);
        exp_irdata = '0;
        exp_drdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_irdata = '0;
        exp_drdata = '0;
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        memIAddr   = '0;
        reqI       = 1'b0;
        memDAddr   = '0;
        memDData   = '0;
        wr         = 1'b0;
        reqD       = 1'b0;
        memBusyIn  = 1'b0;
        memDataOut = '0;
        exp_irdata = '0;
        exp_drdata = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Fetch only, 2-cycle memory latency.
        memIAddr = 32'h4;
        reqI     = 1'b1;
        xact("i_read", 2, 32'hDEAD_BEEF, 1'b0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0);

        // Store from D.
        memDAddr = 32'h8;
        memDData = 32'hA5;
        wr       = 1'b1;
        reqD     = 1'b1;
        xact("d_write", 1, 32'h0000_0055, 1'b1, 32'h8, 1'b1, 32'hA5, 1'b0, 1'b0);

        // Both ports held high after reset: D, I, D, I.
        do_reset();
        memIAddr = 32'h100;
        memDAddr = 32'h200;
        memDData = 32'h33;
        wr       = 1'b0;
        reqI     = 1'b1;
        reqD     = 1'b1;
        xact("rr0_d", 1, 32'h1111_0000, 1'b1, 32'h200, 1'b0, 32'h33, 1'b1, 1'b0);
        xact("rr1_i", 1, 32'h1111_0001, 1'b0, 32'h100, 1'b0, 32'h33, 1'b1, 1'b0);
        xact("rr2_d", 1, 32'h1111_0002, 1'b1, 32'h200, 1'b0, 32'h33, 1'b1, 1'b0);
        xact("rr3_i", 1, 32'h1111_0003, 1'b0, 32'h100, 1'b0, 32'h33, 1'b0, 1'b0);

        // Long busy with inputs changing during WAIT; D load.
        memDAddr = 32'h40;
        memDData = 32'h77;
        wr       = 1'b0;
        reqD     = 1'b1;
        xact("long_busy", 10, 32'hCAFE_F00D, 1'b1, 32'h40, 1'b0, 32'h77, 1'b0, 1'b1);
        wr = 1'b0;

        // Busy high while idle is ignored.
        memBusyIn = 1'b1;
        tick();
        tick();
        chk("idle_busy:memReq", {31'd0, memReq}, 32'd0);
        chk("idle_busy:ready", {30'd0, memIReady, memDReady}, 32'd0);
        memBusyIn = 1'b0;
        tick();

        // Reset during WAIT abandons the access, then D wins afresh.
        do_reset();
        memIAddr = 32'h300;
        memDAddr = 32'h400;
        memDData = 32'h5;
        reqI     = 1'b1;
        reqD     = 1'b1;
        xact("pre_rst_d", 1, 32'h2222_0000, 1'b1, 32'h400, 1'b0, 32'h5, 1'b1, 1'b0);
        n = 0;
        while (!memReq && n < 20) begin
            tick();
            n++;
        end
        chk("pre_rst_i:grantD", {31'd0, grantD}, 32'd0);
        chk("pre_rst_i:memAddr", memAddr, 32'h300);
        memBusyIn = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_in_wait");
        reset     = 1'b0;
        memBusyIn = 1'b0;
        tick();
        chk("post_rst:grantD", {31'd0, grantD}, 32'd1);
        chk("post_rst:ready", {30'd0, memIReady, memDReady}, 32'd0);
        xact("post_rst_d", 1, 32'h3333_0000, 1'b1, 32'h400, 1'b0, 32'h5, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Stuck-busy memory: watchdog completes with zero data, sticky error.
        do_reset();
        chk("to:arbErr_reset", {31'd0, arbErr}, 32'd0);
        memIAddr = 32'h500;
        reqI     = 1'b1;
        n = 0;
        while (!memReq && n < 20) begin
            tick();
            n++;
        end
        memBusyIn = 1'b1;
        n = 0;
        while (!memIReady && n < 30) begin
            tick();
            n++;
        end
        chk("to:ready", {31'd0, memIReady}, 32'd1);
        chk("to:irdata", memIRdata, 32'd0);
        chk("to:arbErr", {31'd0, arbErr}, 32'd1);
        reqI = 1'b0;
        tick();
        tick();
        tick();
        chk("to:arbErr_sticky", {31'd0, arbErr}, 32'd1);
        memBusyIn = 1'b0;
        do_reset();
        chk("to:arbErr_cleared", {31'd0, arbErr}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
